// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: datapath widths and the dump reader state encoding.
package arch_defs_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 4;

    typedef enum logic [2:0] {
        DS_IDLE    = 3'd0,
        DS_REQ     = 3'd1,
        DS_READ    = 3'd2,
        DS_CAPTURE = 3'd3,
        DS_PRESENT = 3'd4,
        DS_DONE    = 3'd5
    } dump_state_t;

endpackage : arch_defs_pkg

// File: rtl/ram_dump_reader.sv
// Readback engine: sweeps an inclusive (possibly wrapping) RAM address range and
// streams each byte out on a valid/ready port, holding the memory bus for the sweep.
module ram_dump_reader #(
    parameter int unsigned DATA_WIDTH = arch_defs_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = arch_defs_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last
);

    import arch_defs_pkg::*;

    // Beat counter is one bit wider so a full-range sweep (2^ADDR_WIDTH beats) fits.
    localparam int unsigned RW = ADDR_WIDTH + 1;

    localparam logic [2:0] ST_IDLE    = 3'(DS_IDLE);
    localparam logic [2:0] ST_REQ     = 3'(DS_REQ);
    localparam logic [2:0] ST_READ    = 3'(DS_READ);
    localparam logic [2:0] ST_CAPTURE = 3'(DS_CAPTURE);
    localparam logic [2:0] ST_PRESENT = 3'(DS_PRESENT);
    localparam logic [2:0] ST_DONE    = 3'(DS_DONE);

    logic [2:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q,  cur_addr_d;
    logic [RW-1:0]         remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic                  out_last_q,  out_last_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  mem_req_q,   mem_req_d;
    logic                  out_valid_q, out_valid_d;
    logic                  mem_rd_c;

    // Next-state, sweep bookkeeping and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        mem_rd_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d  = first_addr;
                    remaining_d = {1'b0, ADDR_WIDTH'(last_addr - first_addr)} + RW'(1);
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Read strobe follows the grant so a lost grant never issues a read.
                mem_rd_c = mem_gnt;
                state_d  = mem_gnt ? ST_CAPTURE : ST_REQ;
            end
            ST_CAPTURE: begin
                out_data_d = mem_rdata;
                out_addr_d = cur_addr_q;
                out_last_d = (remaining_q == RW'(1));
                state_d    = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    if (remaining_q == RW'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                        remaining_d = remaining_q - RW'(1);
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so they flop with it.
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        mem_req_d   = (state_d == ST_REQ) || (state_d == ST_READ) ||
                      (state_d == ST_CAPTURE) || (state_d == ST_PRESENT);
        out_valid_d = (state_d == ST_PRESENT);
    end

    // State and output registers; reset aborts any sweep and releases the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = mem_req_q;
    assign mem_rd    = mem_rd_c;
    assign mem_addr  = cur_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;

endmodule : ram_dump_reader

// File: tb/tb_ram_dump_reader.sv
// Randomized bench for ram_dump_reader with a RAM model and a beat scoreboard.
module tb_ram_dump_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic          busy, done, mem_req, mem_rd, out_valid, out_last;
    logic          mem_gnt = 1'b1;
    logic          out_ready = 1'b1;
    logic [AW-1:0] mem_addr, out_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] out_data;

    logic [DW-1:0] mem [16];

    int n_cmp = 0;
    int n_err = 0;

    ram_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .done(done),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Registered-read RAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stand-in for the CPU store path writing a byte into RAM.
    task automatic sta_store(input logic [3:0] a, input logic [7:0] d);
        mem[a] = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},      32'(busy), 0);
        check_eq({tag, "_done"},      32'(done), 0);
        check_eq({tag, "_mem_req"},   32'(mem_req), 0);
        check_eq({tag, "_mem_rd"},    32'(mem_rd), 0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_out_last"},  32'(out_last), 0);
        check_eq({tag, "_mem_addr"},  32'(mem_addr), 0);
        check_eq({tag, "_out_data"},  32'(out_data), 0);
        check_eq({tag, "_out_addr"},  32'(out_addr), 0);
    endtask

    // One sweep against the scoreboard. e counts rising edges since start was driven;
    // edge 1 is the one that samples start.
    task automatic run_sweep(input int f, input int l, input bit gnt_rand, input bit ready_rand,
                             input int stall_beat, input bit busy_start, input int abort_beat,
                             input bit timing);
        logic [7:0] qd[$];
        logic [3:0] qa[$];
        bit         ql[$];
        int         n, e, stalls, beat, e_last_acc, stall_left;
        bit         seen_valid, hold, finished;
        logic [7:0] pd;
        logic [3:0] pa;
        logic       pl;
        logic [3:0] a;

        n = ((l - f) & 15) + 1;
        for (int i = 0; i < n; i++) begin
            a = 4'((f + i) & 15);
            qa.push_back(a);
            qd.push_back(mem[a]);
            ql.push_back(i == n - 1);
        end

        @(negedge clk);
        start = 1'b1;
        first_addr = 4'(f);
        last_addr = 4'(l);
        mem_gnt = 1'b1;
        out_ready = 1'b1;
        e = 0; stalls = 0; beat = 0; e_last_acc = -10; stall_left = 5;
        seen_valid = 0; hold = 0; finished = 0;
        pd = '0; pa = '0; pl = 1'b0;

        while (!finished) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            start = 1'b0;
            if (busy_start && e == 6) begin
                start = 1'b1;
                first_addr = 4'(f + 5);
                last_addr = 4'(l + 3);
            end

            check_eq("rd_without_gnt", 32'(mem_rd && !mem_gnt), 0);
            check_eq("rd_without_req", 32'(mem_rd && !mem_req), 0);
            check_eq("valid_without_req", 32'(out_valid && !mem_req), 0);
            check_eq("rd_with_valid", 32'(mem_rd && out_valid), 0);

            if (e > 3000) begin
                check_eq("timeout", 32'(e), 0);
                finished = 1;
            end else if (abort_beat >= 0 && out_valid && beat == abort_beat) begin
                reset = 1'b0;
                #1;
                check_idle_outputs("abort");
                @(negedge clk);
                check_eq("abort_no_done", 32'(done), 0);
                reset = 1'b1;
                finished = 1;
            end else if (done) begin
                check_eq("done_after_last", 32'(e), 32'(e_last_acc + 1));
                check_eq("beat_count", 32'(beat), 32'(n));
                check_eq("busy_in_done", 32'(busy), 1);
                check_eq("bus_released_done", 32'(mem_req), 0);
                if (timing) check_eq("done_cycle", 32'(e), 32'(1 + 4 * n + stalls));
                @(negedge clk);
                check_eq("done_pulse_width", 32'(done), 0);
                check_eq("idle_after_done", 32'(busy), 0);
                finished = 1;
            end else begin
                if (out_valid) begin
                    if (!seen_valid) begin
                        seen_valid = 1;
                        if (timing) check_eq("first_valid", 32'(e), 4);
                    end
                    if (hold) begin
                        check_eq("stall_data", 32'(out_data), 32'(pd));
                        check_eq("stall_addr", 32'(out_addr), 32'(pa));
                        check_eq("stall_last", 32'(out_last), 32'(pl));
                    end
                    if (stall_beat == beat && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else if (ready_rand) begin
                        out_ready = ($urandom_range(0, 3) != 0);
                    end else begin
                        out_ready = 1'b1;
                    end
                    if (out_ready) begin
                        check_eq("beat_expected", 32'(qd.size() != 0), 1);
                        if (qd.size() != 0) begin
                            check_eq("beat_data", 32'(out_data), 32'(qd[0]));
                            check_eq("beat_addr", 32'(out_addr), 32'(qa[0]));
                            check_eq("beat_last", 32'(out_last), 32'(ql[0]));
                            void'(qd.pop_front());
                            void'(qa.pop_front());
                            void'(ql.pop_front());
                        end
                        e_last_acc = e;
                        beat++;
                        hold = 0;
                    end else begin
                        stalls++;
                        hold = 1;
                        pd = out_data;
                        pa = out_addr;
                        pl = out_last;
                    end
                end else begin
                    out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                mem_gnt = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end

        start = 1'b0;
        mem_gnt = 1'b1;
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Single byte at the top address
        sta_store(4'hF, 8'h03);
        run_sweep(15, 15, 0, 0, -1, 0, -1, 1);

        // Ordered range
        sta_store(4'h0, 8'h51); sta_store(4'h1, 8'h03);
        sta_store(4'h2, 8'h2F); sta_store(4'h3, 8'hFF);
        run_sweep(0, 3, 0, 0, -1, 0, -1, 1);

        // Wrap-around and full sweep
        sta_store(4'hE, 8'hAA); sta_store(4'hF, 8'hBB); sta_store(4'h0, 8'hCC);
        run_sweep(14, 0, 0, 0, -1, 0, -1, 1);
        run_sweep(14, 1, 0, 0, -1, 0, -1, 1);
        run_sweep(0, 15, 0, 0, -1, 0, -1, 1);

        // Five-cycle consumer stall on the second beat
        run_sweep(0, 3, 0, 0, 1, 0, -1, 1);

        // Grant drops with retries
        run_sweep(3, 10, 1, 0, -1, 0, -1, 0);

        // Start while busy is ignored
        run_sweep(2, 6, 0, 0, -1, 1, -1, 1);

        // Reset in PRESENT, then a clean sweep
        run_sweep(4, 9, 0, 0, -1, 0, 2, 0);
        run_sweep(4, 9, 0, 0, -1, 0, -1, 1);

        // Store then read back
        sta_store(4'hF, 8'h03);
        run_sweep(15, 15, 0, 0, -1, 0, -1, 1);

        // Randomized sweeps
        for (int t = 0; t < 25; t++) begin
            bit gr;
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            gr = 1'($urandom_range(0, 1));
            run_sweep(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), gr,
                      1'($urandom_range(0, 1)), -1, 0, -1, !gr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ram_dump_reader
